// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall/flush control, program-load port and
// the IF/ID register outputs toward decode.
interface if_fetch_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic            PC_SRC;
  logic [XLEN-1:0] BR_TGT;
  logic            STALL;
  logic            FLUSH;
  logic            MEM_WE;
  logic [AW-1:0]   MEM_WADDR;
  logic [XLEN-1:0] MEM_WDATA;
  logic [XLEN-1:0] NEXT_INS_ADR;
  logic [XLEN-1:0] CUR_INS;
  logic            INS_VALID;
  logic            ADDR_ERR;
  logic [XLEN-1:0] PC_OUT;

  // Pipeline control / loader side
  modport master (
    output PC_SRC, BR_TGT, STALL, FLUSH, MEM_WE, MEM_WADDR, MEM_WDATA,
    input  NEXT_INS_ADR, CUR_INS, INS_VALID, ADDR_ERR, PC_OUT
  );

  // Fetch stage side
  modport slave (
    input  PC_SRC, BR_TGT, STALL, FLUSH, MEM_WE, MEM_WADDR, MEM_WDATA,
    output NEXT_INS_ADR, CUR_INS, INS_VALID, ADDR_ERR, PC_OUT
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, word-organised instruction memory
// with a synchronous load port, and the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 1024,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] NOP_INS   = '0
) (
  input logic            CLK,
  input logic            RST_N,
  if_fetch_stage_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fa_next;
  logic [AW-1:0]   idx;
  logic            addr_bad;
  logic            wr_ok;

  logic [XLEN-1:0] cur_ins_q;
  logic [XLEN-1:0] next_adr_q;
  logic            valid_q;
  logic            err_q;

  // Fetch address selection, word index and address-error decode
  always_comb begin
    fa       = bus.PC_SRC ? bus.BR_TGT : pc;
    fa_next  = fa + XLEN'(4);
    idx      = fa[AW+1:2];
    addr_bad = (fa[1:0] != 2'b00) || (fa[XLEN-1:2] >= (XLEN-2)'(DEPTH));
    wr_ok    = bus.MEM_WE && ({1'b0, bus.MEM_WADDR} < (AW+1)'(DEPTH));
  end

  // Program-load write port; reads in the same edge see the old word
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[bus.MEM_WADDR] <= bus.MEM_WDATA;
    end
  end

  // PC register: a stall still captures a redirect target
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc <= RESET_VEC;
    end else if (bus.STALL) begin
      pc <= fa;
    end else begin
      pc <= fa_next;
    end
  end

  // IF/ID register: flush beats stall; bad addresses inject a bubble
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_ins_q  <= NOP_INS;
      next_adr_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (bus.FLUSH) begin
      cur_ins_q  <= NOP_INS;
      next_adr_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (!bus.STALL) begin
      next_adr_q <= fa_next;
      if (addr_bad) begin
        cur_ins_q <= NOP_INS;
        valid_q   <= 1'b0;
        err_q     <= 1'b1;
      end else begin
        cur_ins_q <= mem[idx];
        valid_q   <= 1'b1;
        err_q     <= 1'b0;
      end
    end
  end

  // Direct register outputs
  always_comb begin
    bus.PC_OUT       = pc;
    bus.CUR_INS      = cur_ins_q;
    bus.NEXT_INS_ADR = next_adr_q;
    bus.INS_VALID    = valid_q;
    bus.ADDR_ERR     = err_q;
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed redirect/stall/flush/error/collision
// sequence, a behavioural reference compared every cycle, plus literal checks.
module tb_if_fetch_stage;
  localparam int unsigned     XLEN  = 32;
  localparam int unsigned     DEPTH = 16;
  localparam logic [31:0]     RVEC  = 32'h0;
  localparam logic [31:0]     NOP   = 32'h0000_0013;

  logic CLK;
  logic RST_N;

  if_fetch_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  if_fetch_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_VEC(RVEC), .NOP_INS(NOP)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_cur, m_nia;
  logic        m_val, m_err;

  function automatic logic is_bad(input logic [31:0] a);
    return ((a & 32'd3) != 0) || ((a >> 2) >= DEPTH);
  endfunction

  always @(posedge CLK) begin
    if (bus.MEM_WE && (int'(bus.MEM_WADDR) < DEPTH))
      m_mem[bus.MEM_WADDR] <= bus.MEM_WDATA;
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pc  <= RVEC;
      m_cur <= NOP;
      m_nia <= 32'd0;
      m_val <= 1'b0;
      m_err <= 1'b0;
    end else begin
      logic [31:0] a;
      a = bus.PC_SRC ? bus.BR_TGT : m_pc;
      m_pc <= bus.STALL ? a : a + 32'd4;
      if (bus.FLUSH) begin
        m_cur <= NOP; m_nia <= 32'd0; m_val <= 1'b0; m_err <= 1'b0;
      end else if (!bus.STALL) begin
        m_nia <= a + 32'd4;
        if (is_bad(a)) begin
          m_cur <= NOP; m_val <= 1'b0; m_err <= 1'b1;
        end else begin
          m_cur <= m_mem[a >> 2]; m_val <= 1'b1; m_err <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    chk("m_cur",   bus.CUR_INS,             m_cur);
    chk("m_nia",   bus.NEXT_INS_ADR,        m_nia);
    chk("m_valid", {31'd0, bus.INS_VALID},  {31'd0, m_val});
    chk("m_err",   {31'd0, bus.ADDR_ERR},   {31'd0, m_err});
    chk("m_pc",    bus.PC_OUT,              m_pc);
  end

  // ---------------- directed stimulus ----------------
  task automatic expect_out(input string tag, input logic [31:0] cur, input logic [31:0] nia,
                            input logic val, input logic err, input logic [31:0] pc);
    chk({tag, ".cur"},   bus.CUR_INS,            cur);
    chk({tag, ".nia"},   bus.NEXT_INS_ADR,       nia);
    chk({tag, ".valid"}, {31'd0, bus.INS_VALID}, {31'd0, val});
    chk({tag, ".err"},   {31'd0, bus.ADDR_ERR},  {31'd0, err});
    chk({tag, ".pc"},    bus.PC_OUT,             pc);
  endtask

  task automatic cyc(input logic src, input logic [31:0] tgt, input logic st, input logic fl);
    bus.PC_SRC = src;
    bus.BR_TGT = tgt;
    bus.STALL  = st;
    bus.FLUSH  = fl;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre [4];
    pre = '{32'd11, 32'd22, 32'd33, 32'd44};
    RST_N         = 1'b0;
    bus.PC_SRC    = 1'b0;
    bus.BR_TGT    = '0;
    bus.STALL     = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_WADDR = '0;
    bus.MEM_WDATA = '0;

    // Preload while held in reset (memory is not reset)
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.MEM_WE    = 1'b1;
      bus.MEM_WADDR = 4'(i);
      bus.MEM_WDATA = (i < 4) ? pre[i] : 32'(100 + i);
      @(negedge CLK);
    end
    bus.MEM_WE = 1'b0;
    expect_out("reset", NOP, 32'd0, 1'b0, 1'b0, 32'd0);
    RST_N = 1'b1;

    // Sequential fetch
    cyc(0, 0, 0, 0); expect_out("seq0", 32'd11, 32'd4,  1, 0, 32'd4);
    cyc(0, 0, 0, 0); expect_out("seq1", 32'd22, 32'd8,  1, 0, 32'd8);
    cyc(0, 0, 0, 0); expect_out("seq2", 32'd33, 32'd12, 1, 0, 32'd12);
    cyc(0, 0, 0, 0); expect_out("seq3", 32'd44, 32'd16, 1, 0, 32'd16);

    // Redirect
    cyc(1, 4, 0, 0); expect_out("redir4", 32'd22, 32'd8, 1, 0, 32'd8);
    cyc(1, 0, 0, 0); expect_out("redir0", 32'd11, 32'd4, 1, 0, 32'd4);

    // Stall with redirect captured in the first stalled cycle
    cyc(1, 12, 1, 0); expect_out("stall0", 32'd11, 32'd4,  1, 0, 32'd12);
    cyc(0, 0, 1, 0);  expect_out("stall1", 32'd11, 32'd4,  1, 0, 32'd12);
    cyc(0, 0, 0, 0);  expect_out("unstl",  32'd44, 32'd16, 1, 0, 32'd16);

    // Flush with and without stall
    cyc(0, 0, 1, 1); expect_out("flst", NOP, 32'd0, 0, 0, 32'd16);
    cyc(0, 0, 0, 1); expect_out("fl",   NOP, 32'd0, 0, 0, 32'd20);

    // Address errors
    cyc(1, 6, 0, 0);  expect_out("mis",   NOP, 32'd10, 0, 1, 32'd10);
    cyc(0, 0, 0, 0);  expect_out("mis2",  NOP, 32'd14, 0, 1, 32'd14);
    cyc(1, 64, 0, 0); expect_out("oor",   NOP, 32'd68, 0, 1, 32'd68);
    cyc(1, 0, 0, 0);  expect_out("clr",   32'd11, 32'd4, 1, 0, 32'd4);
    cyc(1, 60, 0, 0); expect_out("last",  32'd115, 32'd64, 1, 0, 32'd64);
    cyc(0, 0, 0, 0);  expect_out("past",  NOP, 32'd68, 0, 1, 32'd68);
    cyc(1, 32'hFFFF_FFFC, 0, 0); expect_out("wrap", NOP, 32'd0, 0, 1, 32'd0);
    cyc(0, 0, 0, 0);  expect_out("wrap0", 32'd11, 32'd4, 1, 0, 32'd4);

    // Write/read collision: same-edge fetch sees old word
    bus.MEM_WE = 1'b1; bus.MEM_WADDR = 4'd1; bus.MEM_WDATA = 32'd99;
    cyc(1, 4, 0, 0); expect_out("coll", 32'd22, 32'd8, 1, 0, 32'd8);
    bus.MEM_WE = 1'b0;
    cyc(1, 4, 0, 0); expect_out("refetch", 32'd99, 32'd8, 1, 0, 32'd8);
    cyc(0, 0, 0, 0); expect_out("after", 32'd33, 32'd12, 1, 0, 32'd12);

    // Asynchronous reset pulse between edges
    #2 RST_N = 1'b0;
    #1 expect_out("areset", NOP, 32'd0, 0, 0, RVEC);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(0, 0, 0, 0); expect_out("post_rst", 32'd11, 32'd4, 1, 0, 32'd4);
    cyc(0, 0, 0, 0); expect_out("post_rst1", 32'd99, 32'd8, 1, 0, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Parametrised instruction-fetch stage. It owns the PC register, an internal word-organised instruction memory, and the IF/ID pipeline register. Each cycle it selects the sequential PC or a redirect target, then registers the fetched instruction and its successor address toward decode. It supports stall, flush, address-error detection and a synchronous memory load port for program preload.

Parameters:
XLEN, 32, width of PC, addresses and instruction words
DEPTH, 1024, number of instruction words in memory; localparam AW = clog2(DEPTH)
RESET_VEC, 0, PC value after reset
NOP_INS, 32'h00000000, instruction word injected on flush or address error

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous, active-low reset
PC_SRC  input  1  1 = fetch from BR_TGT this cycle, 0 = fetch from PC
BR_TGT  input  XLEN  redirect (branch/jump) target byte address
STALL  input  1  hold IF/ID outputs; PC holds unless redirected
FLUSH  input  1  load NOP bubble into IF/ID
MEM_WE  input  1  instruction memory write enable
MEM_WADDR  input  AW  word index for write
MEM_WDATA  input  XLEN  write data
NEXT_INS_ADR  output  XLEN  registered fetch address + 4
CUR_INS  output  XLEN  registered fetched instruction
INS_VALID  output  1  CUR_INS is a real instruction
ADDR_ERR  output  1  registered: last fetch was misaligned or out of range
PC_OUT  output  XLEN  current PC register value

Behaviour:
- Reset (RST_N low, async): PC = RESET_VEC; CUR_INS = NOP_INS; NEXT_INS_ADR = 0; INS_VALID = 0; ADDR_ERR = 0. Memory contents are not reset.
- Fetch address FA = PC_SRC ? BR_TGT : PC (combinational). Word index = FA[AW+1:2].
- Normal cycle (STALL=0, FLUSH=0), on the rising edge:
  - PC <= FA+4
  - NEXT_INS_ADR <= FA+4
  - CUR_INS <= mem[index]
  - INS_VALID <= 1
  - ADDR_ERR <= 0
  - Latency is 1 cycle from FA to CUR_INS.
- Address error: if FA[1:0] != 0, or FA[XLEN-1:2] >= DEPTH:
  - CUR_INS <= NOP_INS; INS_VALID <= 0; ADDR_ERR <= 1
  - NEXT_INS_ADR <= FA+4; PC <= FA+4
  - The error repeats every cycle until a redirect.
- Arithmetic: FA+4 is modulo 2^XLEN. FA = 2^XLEN-4 yields 0.
- STALL=1, FLUSH=0:
  - IF/ID outputs (CUR_INS, NEXT_INS_ADR, INS_VALID, ADDR_ERR) hold.
  - PC <= PC_SRC ? BR_TGT : PC, so a redirect during a stall is captured, not lost.
  - The first unstalled cycle fetches from the updated PC.
- FLUSH=1 (any STALL):
  - CUR_INS <= NOP_INS; INS_VALID <= 0; NEXT_INS_ADR <= 0; ADDR_ERR <= 0
  - With STALL=0, PC updates per the normal rule (FA+4).
  - With STALL=1, PC updates per the stall rule.
  - FLUSH has priority over STALL for the IF/ID register.
- Memory write:
  - Synchronous on the rising edge when MEM_WE=1 and MEM_WADDR < DEPTH. Writes at MEM_WADDR >= DEPTH are ignored.
  - A same-cycle fetch of the written word returns the old data; the new data is visible on the next fetch.
- PC_OUT is the PC register, a direct register output.
- Reset asserted mid-operation immediately forces all reset values. The first fetch after release is from RESET_VEC.

Test Plan:
- Preload mem[0..3] = 11,22,33,44. Release reset with PC_SRC=0 -> CUR_INS 11,22,33,44 on successive cycles; NEXT_INS_ADR 4,8,12,16; INS_VALID=1 from the first edge after reset.
- Redirect: PC=8, PC_SRC=1, BR_TGT=0 -> next CUR_INS=11, NEXT_INS_ADR=4, PC_OUT=4.
- Stall with redirect: assert STALL for 2 cycles with PC_SRC=1, BR_TGT=12 in the first cycle -> outputs frozen; after release CUR_INS=44, NEXT_INS_ADR=16.
- Flush with stall: FLUSH=1, STALL=1 -> CUR_INS=0, INS_VALID=0, NEXT_INS_ADR=0, PC unchanged. FLUSH=1 alone -> same outputs, PC advances by 4.
- Errors: BR_TGT=6 -> ADDR_ERR=1, INS_VALID=0, CUR_INS=NOP_INS, PC_OUT=10. BR_TGT=DEPTH*4 -> ADDR_ERR=1. A subsequent redirect to 0 clears ADDR_ERR.
- Write/read collision: MEM_WE at index 1 = 99 while fetching FA=4 -> CUR_INS=22; refetch FA=4 -> 99. Reset pulse mid-run -> outputs return to reset values at once, PC_OUT=RESET_VEC.
